// File: rtl/rt_stream_bridge_pkg.sv
// Shared types and constants for the RT core host stream bridge.
// Contents: record widths, host word geometry, result field offsets, FSM state enums and a
// word-count helper used to size the ray assembler.
package rt_stream_bridge_pkg;

  localparam int unsigned RAY_WIDTH       = 200;
  localparam int unsigned RESULT_WIDTH    = 97;
  localparam int unsigned CNT_WIDTH       = 16;
  localparam int unsigned HOST_WORD_WIDTH = 32;
  localparam int unsigned RESULT_WORDS    = 4;

  // Result record layout: bit 0 = hit, then three 32-bit fields packed upward.
  localparam int unsigned RESULT_HIT_BIT  = 0;
  localparam int unsigned RESULT_F0_LSB   = 1;
  localparam int unsigned RESULT_F1_LSB   = 33;
  localparam int unsigned RESULT_F2_LSB   = 65;

  // Ray record: host word k lands at bits [32*k +: 32], little-endian word order.
  localparam int unsigned RAY_WORD0_LSB   = 0;

  typedef enum logic {RayCollect, RaySend} ray_state_e;
  typedef enum logic {ResIdle, ResEmit} res_state_e;

  function automatic int unsigned num_words(input int unsigned width);
    return (width + HOST_WORD_WIDTH - 1) / HOST_WORD_WIDTH;
  endfunction

endpackage

// File: rtl/rt_result_serializer.sv
// Result path of the stream bridge: pops one result record from the core's result stream and
// emits it to the host as four 32-bit words.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   result_stream_empty_n     core has a result (dout valid while high)
//   result_stream_read        pop request (registered, forced low during rst)
//   result_stream_dout        result record
//   host_out_valid/ready      host word handshake
//   host_out_data             result word
//   host_out_last             high on word 3
module rt_result_serializer
  import rt_stream_bridge_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = rt_stream_bridge_pkg::RESULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    result_stream_empty_n,
  output logic                    result_stream_read,
  input  logic [RESULT_WIDTH-1:0] result_stream_dout,
  output logic                    host_out_valid,
  input  logic                    host_out_ready,
  output logic [31:0]             host_out_data,
  output logic                    host_out_last
);

  res_state_e              state_q;
  logic [1:0]              wi_q;
  logic [RESULT_WIDTH-1:0] rec_q;
  logic                    read_q;
  logic                    valid_q;
  logic [31:0]             data_q;
  logic                    last_q;

  // Word 0 carries the hit flag; the fields are zeroed on a miss.
  function automatic logic [31:0] result_word(input logic [RESULT_WIDTH-1:0] rec,
                                               input logic [1:0]              k);
    logic [31:0] w;
    w = '0;
    case (k)
      2'd0: w = {31'b0, rec[RESULT_HIT_BIT]};
      2'd1: w = rec[RESULT_HIT_BIT] ? rec[RESULT_F0_LSB +: 32] : 32'h0;
      2'd2: w = rec[RESULT_HIT_BIT] ? rec[RESULT_F1_LSB +: 32] : 32'h0;
      default: w = rec[RESULT_HIT_BIT] ? rec[RESULT_F2_LSB +: 32] : 32'h0;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ResIdle;
      wi_q    <= '0;
      rec_q   <= '0;
      read_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        ResIdle: begin
          if (read_q && result_stream_empty_n) begin
            rec_q   <= result_stream_dout;
            wi_q    <= 2'd0;
            state_q <= ResEmit;
            read_q  <= 1'b0;
            valid_q <= 1'b1;
            data_q  <= result_word(result_stream_dout, 2'd0);
            last_q  <= 1'b0;
          end else begin
            read_q <= 1'b1;
          end
        end
        ResEmit: begin
          if (host_out_ready) begin
            if (wi_q == 2'd3) begin
              state_q <= ResIdle;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              read_q  <= 1'b1;
            end else begin
              wi_q   <= wi_q + 2'd1;
              data_q <= result_word(rec_q, wi_q + 2'd1);
              last_q <= (wi_q == 2'd2);
            end
          end
        end
        default: state_q <= ResIdle;
      endcase
    end
  end

  // Handshake outputs are masked during rst so no pop or word transfer happens in that cycle.
  assign result_stream_read = read_q && !rst;
  assign host_out_valid     = valid_q && !rst;
  assign host_out_data      = data_q;
  assign host_out_last      = last_q;

endmodule

// File: rtl/rt_stream_bridge.sv
// Host-side bridge for the RT core streams.
// Ray path: assembles NW host words into one ray and pushes it on the core ray stream.
// Result path: pops core results and serializes them into four host words.
// Also tracks rays in flight and flags result pops with nothing outstanding.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   host_in_valid/ready/data          32-bit ray words from the host
//   ray_stream_write/full_n/din       producer side of the core ray stream
//   result_stream_empty_n/read/dout   consumer side of the core result stream
//   host_out_valid/ready/data/last    32-bit result words to the host
//   in_flight                         rays sent minus results popped
//   err_underflow                     sticky: result popped with in_flight == 0
module rt_stream_bridge
  import rt_stream_bridge_pkg::*;
#(
  parameter int unsigned RAY_WIDTH    = rt_stream_bridge_pkg::RAY_WIDTH,
  parameter int unsigned RESULT_WIDTH = rt_stream_bridge_pkg::RESULT_WIDTH,
  parameter int unsigned CNT_WIDTH    = rt_stream_bridge_pkg::CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    host_in_valid,
  output logic                    host_in_ready,
  input  logic [31:0]             host_in_data,
  output logic                    ray_stream_write,
  input  logic                    ray_stream_full_n,
  output logic [RAY_WIDTH-1:0]    ray_stream_din,
  input  logic                    result_stream_empty_n,
  output logic                    result_stream_read,
  input  logic [RESULT_WIDTH-1:0] result_stream_dout,
  output logic                    host_out_valid,
  input  logic                    host_out_ready,
  output logic [31:0]             host_out_data,
  output logic                    host_out_last,
  output logic [CNT_WIDTH-1:0]    in_flight,
  output logic                    err_underflow
);

  localparam int unsigned NW        = num_words(RAY_WIDTH);
  localparam int unsigned WI_W      = (NW > 1) ? $clog2(NW) : 1;
  // Bits of the final host word that fit in the ray; the rest are dropped.
  localparam int unsigned LAST_BITS = RAY_WIDTH - HOST_WORD_WIDTH * (NW - 1);

  // ---------------------------------------------------------------------------------------
  // Ray assembler
  // ---------------------------------------------------------------------------------------
  ray_state_e                            ray_state_q;
  logic [WI_W-1:0]                       wi_q;
  logic [NW-2:0][HOST_WORD_WIDTH-1:0]    full_words_q;
  logic [LAST_BITS-1:0]                  last_word_q;
  logic                                  in_ready_q;
  logic                                  write_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ray_state_q  <= RayCollect;
      wi_q         <= '0;
      full_words_q <= '0;
      last_word_q  <= '0;
      in_ready_q   <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      case (ray_state_q)
        RayCollect: begin
          in_ready_q <= 1'b1;
          if (in_ready_q && host_in_valid) begin
            if (wi_q == WI_W'(NW - 1)) begin
              last_word_q <= host_in_data[LAST_BITS-1:0];
              wi_q        <= '0;
              ray_state_q <= RaySend;
              in_ready_q  <= 1'b0;
              write_q     <= 1'b1;
            end else begin
              full_words_q[wi_q] <= host_in_data;
              wi_q               <= wi_q + WI_W'(1);
            end
          end
        end
        RaySend: begin
          // din is the assembly register itself, so it holds until the core takes it.
          if (ray_stream_full_n) begin
            ray_state_q <= RayCollect;
            write_q     <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: ray_state_q <= RayCollect;
      endcase
    end
  end

  assign host_in_ready    = in_ready_q && !rst;
  assign ray_stream_write = write_q && !rst;
  assign ray_stream_din   = {last_word_q, full_words_q};

  // ---------------------------------------------------------------------------------------
  // Result serializer
  // ---------------------------------------------------------------------------------------
  rt_result_serializer #(
    .RESULT_WIDTH (RESULT_WIDTH)
  ) u_result_serializer (
    .clk                   (clk),
    .rst                   (rst),
    .result_stream_empty_n (result_stream_empty_n),
    .result_stream_read    (result_stream_read),
    .result_stream_dout    (result_stream_dout),
    .host_out_valid        (host_out_valid),
    .host_out_ready        (host_out_ready),
    .host_out_data         (host_out_data),
    .host_out_last         (host_out_last)
  );

  // ---------------------------------------------------------------------------------------
  // In-flight tracking
  // ---------------------------------------------------------------------------------------
  logic                 ray_xfer;
  logic                 res_pop;
  logic [CNT_WIDTH-1:0] in_flight_q;
  logic                 err_q;

  assign ray_xfer = ray_stream_write && ray_stream_full_n;
  assign res_pop  = result_stream_read && result_stream_empty_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case ({ray_xfer, res_pop})
        2'b10: in_flight_q <= in_flight_q + CNT_WIDTH'(1);
        2'b01: begin
          if (in_flight_q == '0) begin
            err_q <= 1'b1;
          end else begin
            in_flight_q <= in_flight_q - CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_flight     = in_flight_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_rt_stream_bridge.sv
module tb_rt_stream_bridge;

  logic         clk;
  logic         rst;
  logic         host_in_valid;
  logic         host_in_ready;
  logic [31:0]  host_in_data;
  logic         ray_stream_write;
  logic         ray_stream_full_n;
  logic [199:0] ray_stream_din;
  logic         result_stream_empty_n;
  logic         result_stream_read;
  logic [96:0]  result_stream_dout;
  logic         host_out_valid;
  logic         host_out_ready;
  logic [31:0]  host_out_data;
  logic         host_out_last;
  logic [15:0]  in_flight;
  logic         err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rw [7];

  typedef struct {
    logic             hit;
    logic [31:0]      f0;
    logic [31:0]      f1;
    logic [31:0]      f2;
    logic [5:0]       rdy;
    logic [3:0][31:0] w;
    logic [15:0]      inflight;
    logic             err;
  } res_vec_t;

  res_vec_t vecs [4];

  rt_stream_bridge #(
    .RAY_WIDTH    (200),
    .RESULT_WIDTH (97),
    .CNT_WIDTH    (16)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .host_in_valid         (host_in_valid),
    .host_in_ready         (host_in_ready),
    .host_in_data          (host_in_data),
    .ray_stream_write      (ray_stream_write),
    .ray_stream_full_n     (ray_stream_full_n),
    .ray_stream_din        (ray_stream_din),
    .result_stream_empty_n (result_stream_empty_n),
    .result_stream_read    (result_stream_read),
    .result_stream_dout    (result_stream_dout),
    .host_out_valid        (host_out_valid),
    .host_out_ready        (host_out_ready),
    .host_out_data         (host_out_data),
    .host_out_last         (host_out_last),
    .in_flight             (in_flight),
    .err_underflow         (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [199:0] exp_ray();
    logic [6:0][31:0] t;
    for (int i = 0; i < 7; i++) t[3'(i)] = rw[3'(i)];
    return 200'(t);
  endfunction

  // Presents one word and returns at posedge+1 after the edge that accepted it.
  task automatic put_word(input logic [31:0] w);
    int n;
    n = 0;
    host_in_valid = 1'b1;
    host_in_data  = w;
    #1;
    while (!host_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 256'(host_in_ready), 256'(1));
    @(posedge clk); #1;
    host_in_valid = 1'b0;
  endtask

  task automatic send_words(input int first, input int last);
    for (int i = first; i < last; i++) put_word(rw[3'(i)]);
  endtask

  // Offers one result and returns at posedge+1 after the popping edge.
  task automatic pop(input logic hit, input logic [31:0] f0, input logic [31:0] f1,
                     input logic [31:0] f2, input string tag);
    int n;
    n = 0;
    result_stream_dout    = {f2, f1, f0, hit};
    result_stream_empty_n = 1'b1;
    #1;
    while (!result_stream_read && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_read"}, 256'(result_stream_read), 256'(1));
    @(posedge clk); #1;
    result_stream_empty_n = 1'b0;
    result_stream_dout    = '0;
  endtask

  // Collects four words under a cyclic ready pattern; every valid cycle is compared.
  task automatic drain(input logic [3:0][31:0] exp_w, input logic [5:0] rdy, input string tag);
    int idx;
    int cn;
    idx = 0;
    cn  = 0;
    while (idx < 4 && cn < 60) begin
      host_out_ready = rdy[3'(cn % 6)];
      #1;
      if (host_out_valid) begin
        check({tag, "_data"}, 256'(host_out_data), 256'(exp_w[2'(idx)]));
        check({tag, "_last"}, 256'(host_out_last), 256'(idx == 3));
        if (host_out_ready) idx++;
      end
      @(posedge clk); #1;
      cn++;
    end
    check({tag, "_count"}, 256'(idx), 256'(4));
    host_out_ready = 1'b0;
    #1;
    check({tag, "_valid_after"}, 256'(host_out_valid), 256'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 256'(host_in_ready), 256'(0));
    check({tag, "_write"}, 256'(ray_stream_write), 256'(0));
    check({tag, "_din"}, 256'(ray_stream_din), 256'(0));
    check({tag, "_read"}, 256'(result_stream_read), 256'(0));
    check({tag, "_out_valid"}, 256'(host_out_valid), 256'(0));
    check({tag, "_out_data"}, 256'(host_out_data), 256'(0));
    check({tag, "_out_last"}, 256'(host_out_last), 256'(0));
    check({tag, "_in_flight"}, 256'(in_flight), 256'(0));
    check({tag, "_err"}, 256'(err_underflow), 256'(0));
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h3F800000, 32'h11223344, 32'hDEADBEEF, 6'b101101,
                {32'hDEADBEEF, 32'h11223344, 32'h3F800000, 32'h00000001}, 16'd2, 1'b0};
    vecs[1] = '{1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 6'b111111,
                {32'h0, 32'h0, 32'h0, 32'h0}, 16'd1, 1'b0};
    vecs[2] = '{1'b1, 32'h0, 32'h0, 32'h0, 6'b111111,
                {32'h0, 32'h0, 32'h0, 32'h00000001}, 16'd0, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'h80000001, 32'h00000002, 6'b110011,
                {32'h00000002, 32'h80000001, 32'hFFFFFFFF, 32'h00000001}, 16'd0, 1'b1};

    rst                   = 1'b1;
    host_in_valid         = 1'b0;
    host_in_data          = '0;
    ray_stream_full_n     = 1'b0;
    result_stream_empty_n = 1'b0;
    result_stream_dout    = '0;
    host_out_ready        = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: seven words, core ready
    ray_stream_full_n = 1'b1;
    for (int i = 0; i < 7; i++) rw[3'(i)] = 32'(i + 1);
    send_words(0, 7);
    check("t1_write", 256'(ray_stream_write), 256'(1));
    check("t1_din_lo", 256'(ray_stream_din[31:0]), 256'(32'h1));
    check("t1_din_hi", 256'(ray_stream_din[199:192]), 256'(8'h07));
    check("t1_din", 256'(ray_stream_din), 256'(exp_ray()));
    @(posedge clk); #1;
    check("t1_write_1cyc", 256'(ray_stream_write), 256'(0));
    check("t1_in_flight", 256'(in_flight), 256'(1));
    check("t1_in_ready", 256'(host_in_ready), 256'(1));

    // Test 2: core stalls 5 cycles; a word offered meanwhile waits
    ray_stream_full_n = 1'b0;
    for (int i = 0; i < 7; i++) rw[3'(i)] = 32'h10 + 32'(i);
    send_words(0, 7);
    host_in_valid = 1'b1;
    host_in_data  = 32'hAA;
    for (int k = 0; k < 5; k++) begin
      check("t2_write_hold", 256'(ray_stream_write), 256'(1));
      check("t2_din_hold", 256'(ray_stream_din), 256'(exp_ray()));
      check("t2_in_ready", 256'(host_in_ready), 256'(0));
      @(posedge clk); #1;
    end
    check("t2_in_flight_held", 256'(in_flight), 256'(1));
    ray_stream_full_n = 1'b1;
    @(posedge clk); #1;
    check("t2_write_done", 256'(ray_stream_write), 256'(0));
    check("t2_in_flight", 256'(in_flight), 256'(2));
    check("t2_in_ready_back", 256'(host_in_ready), 256'(1));
    @(posedge clk); #1;
    host_in_valid = 1'b0;
    rw[0] = 32'hAA;
    for (int i = 1; i < 7; i++) rw[3'(i)] = 32'hAA + 32'(i);
    send_words(1, 7);
    check("t2_din_word0", 256'(ray_stream_din[31:0]), 256'(32'hAA));
    check("t2_din_next", 256'(ray_stream_din), 256'(exp_ray()));
    @(posedge clk); #1;
    check("t2_in_flight3", 256'(in_flight), 256'(3));

    // Test 5a: ray transfer and result pop in the same cycle
    ray_stream_full_n = 1'b0;
    for (int i = 0; i < 7; i++) rw[3'(i)] = 32'h20 + 32'(i);
    send_words(0, 7);
    check("t5_write", 256'(ray_stream_write), 256'(1));
    ray_stream_full_n     = 1'b1;
    result_stream_dout    = {32'd3, 32'd2, 32'd1, 1'b1};
    result_stream_empty_n = 1'b1;
    #1;
    check("t5_read", 256'(result_stream_read), 256'(1));
    @(posedge clk); #1;
    result_stream_empty_n = 1'b0;
    check("t5_in_flight_same", 256'(in_flight), 256'(3));
    check("t5_write_done", 256'(ray_stream_write), 256'(0));
    check("t5_out_valid", 256'(host_out_valid), 256'(1));
    drain({32'd3, 32'd2, 32'd1, 32'd1}, 6'b111111, "t5");

    // Tests 3, 4, 5b: result table
    for (int v = 0; v < 4; v++) begin
      pop(vecs[v].hit, vecs[v].f0, vecs[v].f1, vecs[v].f2, $sformatf("vec%0d", v));
      drain(vecs[v].w, vecs[v].rdy, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_in_flight", v), 256'(in_flight), 256'(vecs[v].inflight));
      check($sformatf("vec%0d_err", v), 256'(err_underflow), 256'(vecs[v].err));
    end

    // Test 6: reset mid-emit (word 2) and mid-assembly (4 of 7 words)
    pop(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "t6_res");
    host_out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    host_out_ready = 1'b0;
    #1;
    check("t6_mid_valid", 256'(host_out_valid), 256'(1));
    check("t6_mid_word2", 256'(host_out_data), 256'(32'hFFFFFFFF));
    for (int i = 0; i < 7; i++) rw[3'(i)] = 32'hFFFFFFFF;
    send_words(0, 4);
    rst           = 1'b1;
    host_in_valid = 1'b0;
    #1;
    check("t6_rst_write", 256'(ray_stream_write), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_all_zero("t6_after_rst");
    for (int i = 0; i < 7; i++) rw[3'(i)] = 32'h31 + 32'(i);
    send_words(0, 7);
    check("t6_fresh_din", 256'(ray_stream_din), 256'(exp_ray()));
    @(posedge clk); #1;
    check("t6_in_flight", 256'(in_flight), 256'(1));
    pop(1'b1, 32'd5, 32'd6, 32'd7, "t6_post");
    drain({32'd7, 32'd6, 32'd5, 32'd1}, 6'b111111, "t6_post");
    check("t6_in_flight_end", 256'(in_flight), 256'(0));
    check("t6_err_end", 256'(err_underflow), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
